// File: rtl/led_slot_scheduler.sv
// RED/IR LED time-multiplexing scheduler for the pulse-oximeter front end.
// Each frame runs a RED slot and then an IR slot. In every slot the scheduler drives
// the LED, DC_Comp and PGA_Gain, ignores ADC codes while the front end settles,
// averages 2**AVG_LOG2 samples, and pulses sample_valid once the frame ends.
// Optional feature: define AMBIENT_SUB_EN to add a DARK slot after IR. Its
// ambient average is subtracted from the RED and IR results, saturating at 0.
module led_slot_scheduler #(
  parameter int unsigned SLOT_CYCLES   = 10,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [6:0] RED_DC_Comp,
  input  logic [3:0] RED_PGA,
  input  logic [6:0] IR_DC_Comp,
  input  logic [3:0] IR_PGA,
  input  logic [7:0] ADC,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic [7:0] RED_ADC_Value,
  output logic [7:0] IR_ADC_Value,
  output logic       sample_valid,
  output logic       busy
);

  localparam int unsigned NumAvg = 2 ** AVG_LOG2;
  localparam int unsigned CntW   = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned AccW   = 8 + AVG_LOG2;
  localparam logic [CntW-1:0] LastCnt = CntW'(SLOT_CYCLES - 1);
  localparam logic [CntW-1:0] WinLo   = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0] WinHi   = CntW'(SETTLE_CYCLES + NumAvg - 1);

  if (SETTLE_CYCLES + NumAvg > SLOT_CYCLES) begin : g_param_check
    $error("led_slot_scheduler: SETTLE_CYCLES + 2**AVG_LOG2 exceeds SLOT_CYCLES");
  end

  typedef enum logic [1:0] {StIdle, StRed, StIr, StDark} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic            stop_pending_q, stop_pending_d;
  logic [6:0]      red_dc_q, red_dc_d, ir_dc_q, ir_dc_d;
  logic [3:0]      red_pga_q, red_pga_d, ir_pga_q, ir_pga_d;
  logic            led_red_q, led_red_d, led_ir_q, led_ir_d;
  logic [6:0]      dc_comp_q, dc_comp_d;
  logic [3:0]      pga_gain_q, pga_gain_d;
  logic [7:0]      red_val_q, red_val_d, ir_val_q, ir_val_d;
  logic            valid_q, valid_d;
`ifdef AMBIENT_SUB_EN
  logic [7:0]      red_raw_q, red_raw_d, ir_raw_q, ir_raw_d;

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction
`endif

  logic            in_win, slot_end, halt, frame_end;
  logic [AccW-1:0] acc_sum;
  logic [7:0]      avg;

  // Sample window, running sum including this cycle's sample, and slot average.
  always_comb begin
    in_win   = (slot_cnt_q >= WinLo) && (slot_cnt_q <= WinHi);
    acc_sum  = acc_q + (in_win ? AccW'(ADC) : '0);
    avg      = 8'(acc_sum >> AVG_LOG2);
    slot_end = (slot_cnt_q == LastCnt);
    halt     = stop_pending_q | stop;
  end

  // Next-state logic: slot sequencing, front-end drive and result capture.
  always_comb begin
    state_d        = state_q;
    slot_cnt_d     = slot_cnt_q;
    acc_d          = acc_q;
    stop_pending_d = stop_pending_q;
    red_dc_d       = red_dc_q;
    red_pga_d      = red_pga_q;
    ir_dc_d        = ir_dc_q;
    ir_pga_d       = ir_pga_q;
    led_red_d      = led_red_q;
    led_ir_d       = led_ir_q;
    dc_comp_d      = dc_comp_q;
    pga_gain_d     = pga_gain_q;
    red_val_d      = red_val_q;
    ir_val_d       = ir_val_q;
    valid_d        = 1'b0;
    frame_end      = 1'b0;
`ifdef AMBIENT_SUB_EN
    red_raw_d      = red_raw_q;
    ir_raw_d       = ir_raw_q;
`endif

    if (state_q == StIdle) begin
      stop_pending_d = 1'b0;
      // stop takes priority over a simultaneous start
      if (start && !stop) begin
        red_dc_d   = RED_DC_Comp;
        red_pga_d  = RED_PGA;
        ir_dc_d    = IR_DC_Comp;
        ir_pga_d   = IR_PGA;
        state_d    = StRed;
        slot_cnt_d = '0;
        acc_d      = '0;
        led_red_d  = 1'b1;
        led_ir_d   = 1'b0;
        dc_comp_d  = RED_DC_Comp;
        pga_gain_d = RED_PGA;
      end
    end else begin
      stop_pending_d = halt;
      acc_d          = acc_sum;
      slot_cnt_d     = slot_cnt_q + 1'b1;
      if (slot_end) begin
        slot_cnt_d = '0;
        acc_d      = '0;
        case (state_q)
          StRed: begin
            red_val_d  = avg;
`ifdef AMBIENT_SUB_EN
            red_raw_d  = avg;
`endif
            state_d    = StIr;
            led_red_d  = 1'b0;
            led_ir_d   = 1'b1;
            dc_comp_d  = ir_dc_q;
            pga_gain_d = ir_pga_q;
          end
          StIr: begin
`ifdef AMBIENT_SUB_EN
            // DARK keeps the IR front-end settings with both LEDs off
            ir_raw_d  = avg;
            state_d   = StDark;
            led_ir_d  = 1'b0;
`else
            ir_val_d  = avg;
            frame_end = 1'b1;
`endif
          end
`ifdef AMBIENT_SUB_EN
          StDark: begin
            red_val_d = sat_sub(red_raw_q, avg);
            ir_val_d  = sat_sub(ir_raw_q, avg);
            frame_end = 1'b1;
          end
`endif
          default: state_d = StIdle;
        endcase
        if (frame_end) begin
          valid_d = 1'b1;
          if (halt) begin
            // DC_Comp/PGA_Gain keep their last values while idle
            state_d        = StIdle;
            stop_pending_d = 1'b0;
            led_red_d      = 1'b0;
            led_ir_d       = 1'b0;
          end else begin
            state_d    = StRed;
            led_red_d  = 1'b1;
            led_ir_d   = 1'b0;
            dc_comp_d  = red_dc_q;
            pga_gain_d = red_pga_q;
          end
        end
      end
    end
  end

  // State register with synchronous active-low reset; reset drops any partial frame.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      slot_cnt_q     <= '0;
      acc_q          <= '0;
      stop_pending_q <= 1'b0;
      red_dc_q       <= '0;
      red_pga_q      <= '0;
      ir_dc_q        <= '0;
      ir_pga_q       <= '0;
      led_red_q      <= 1'b0;
      led_ir_q       <= 1'b0;
      dc_comp_q      <= '0;
      pga_gain_q     <= '0;
      red_val_q      <= '0;
      ir_val_q       <= '0;
      valid_q        <= 1'b0;
`ifdef AMBIENT_SUB_EN
      red_raw_q      <= '0;
      ir_raw_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      slot_cnt_q     <= slot_cnt_d;
      acc_q          <= acc_d;
      stop_pending_q <= stop_pending_d;
      red_dc_q       <= red_dc_d;
      red_pga_q      <= red_pga_d;
      ir_dc_q        <= ir_dc_d;
      ir_pga_q       <= ir_pga_d;
      led_red_q      <= led_red_d;
      led_ir_q       <= led_ir_d;
      dc_comp_q      <= dc_comp_d;
      pga_gain_q     <= pga_gain_d;
      red_val_q      <= red_val_d;
      ir_val_q       <= ir_val_d;
      valid_q        <= valid_d;
`ifdef AMBIENT_SUB_EN
      red_raw_q      <= red_raw_d;
      ir_raw_q       <= ir_raw_d;
`endif
    end
  end

  // Outputs come straight from registers, except busy, which decodes the state.
  always_comb begin
    LED_RED       = led_red_q;
    LED_IR        = led_ir_q;
    DC_Comp       = dc_comp_q;
    PGA_Gain      = pga_gain_q;
    RED_ADC_Value = red_val_q;
    IR_ADC_Value  = ir_val_q;
    sample_valid  = valid_q;
    busy          = (state_q != StIdle);
  end

endmodule
